uart_rx_sampler: RTL and testbench

- Serial receive front end of the UART peripheral.
- Synchronises the raw rx pin, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit using the programmable baud divider. Checks the stop bit.
- Hands each byte to the peripheral register/FIFO stage as a one-cycle valid pulse, or flags a frame error.
- Sits between the uart_rxd pad and the UART top-level rx FIFO.

---
 rtl/uart_rx_sampler_if.sv | 14 +
 rtl/uart_rx_sampler.sv | 78 +++++++
 tb/tb_uart_rx_sampler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line, baud divider and received-byte signals of the rx front end
interface uart_rx_sampler_if #(
    parameter int BAUD_DIV_W = 16,
    parameter int DATA_W     = 8
);
    logic                  rx_pin_in;
    logic [BAUD_DIV_W-1:0] baud_div_i;
    logic [DATA_W-1:0]     rx_data_o;
    logic                  valid_o;
    logic                  frame_err_o;
    logic                  busy_o;
    modport master (output rx_pin_in, baud_div_i, input rx_data_o, valid_o, frame_err_o, busy_o);
    modport slave  (input rx_pin_in, baud_div_i, output rx_data_o, valid_o, frame_err_o, busy_o);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises rx, samples LSB-first data at mid-bit, checks the stop bit
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int BAUD_DIV_W  = 16,
    parameter int DATA_W      = 8
) (
    input logic              clk,
    input logic              rst,
    uart_rx_sampler_if.slave bus
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [BAUD_DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d, cnt_tgt;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d, data_q, data_d;
    logic                   valid_q, valid_d, err_q, err_d, rx_s, tick;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.rx_pin_in};
    assign rx_s    = sync_q[SYNC_STAGES-1];
    // START waits half a bit so every later sample lands mid-bit
    assign cnt_tgt = (state_q == S_START) ? (div_q >> 1) - 1'b1 : div_q - 1'b1;
    assign tick    = cnt_q == cnt_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = rx_s ? S_IDLE : S_START;
            S_START: state_d = !tick ? S_START : rx_s ? S_IDLE : S_DATA;
            S_DATA:  state_d = (tick && idx_q == IW'(DATA_W - 1)) ? S_STOP : S_DATA;
            S_STOP:  state_d = !tick ? S_STOP : rx_s ? S_IDLE : S_BREAK;
            S_BREAK: state_d = rx_s ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d   = (state_q == S_IDLE && !rx_s)
                ? ((bus.baud_div_i < BAUD_DIV_W'(4)) ? BAUD_DIV_W'(4) : bus.baud_div_i) : div_q;
        cnt_d   = (state_d != state_q || tick || state_q == S_IDLE || state_q == S_BREAK)
                ? '0 : cnt_q + 1'b1;
        idx_d   = (state_q != S_DATA) ? '0 : tick ? idx_q + 1'b1 : idx_q;
        shreg_d = (state_q == S_DATA && tick) ? {rx_s, shreg_q[DATA_W-1:1]} : shreg_q;
        valid_d = state_q == S_STOP && tick && rx_s;
        err_d   = state_q == S_STOP && tick && !rx_s;
        data_d  = valid_d ? shreg_q : data_q;
    end

    assign bus.rx_data_o   = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = err_q;
    assign bus.busy_o      = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed and random frames checked against a frame-timing model
module tb_uart_rx_sampler;
    localparam int SYNC = 2;
    localparam int DW   = 8;
    typedef struct {int cyc; logic [7:0] d; logic err;} evt_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    evt_t evq[$];

    uart_rx_sampler_if #(.BAUD_DIV_W(16), .DATA_W(DW)) bus ();
    uart_rx_sampler #(.SYNC_STAGES(SYNC), .BAUD_DIV_W(16), .DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk)
        if (bus.valid_o || bus.frame_err_o) begin
            check("pulse exclusive", 64'(bus.valid_o & bus.frame_err_o), 64'd0);
            evq.push_back('{cyc, bus.rx_data_o, bus.frame_err_o});
        end

    // Start bit driven just after edge e reaches IDLE->START at e+SYNC+1; stop sampled 9 bits after mid-start
    function automatic int exp_cyc(input int e, input int d);
        int v = (d < 4) ? 4 : d;
        return e + SYNC + 1 + v / 2 + (DW + 1) * v;
    endfunction

    task automatic drive(input logic v, input int n);
        bus.rx_pin_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int len, input logic stop,
                        input int chg_bit, input int new_div, output int e);
        e = cyc;
        drive(1'b0, len);
        for (int k = 0; k < DW; k++) begin
            if (k == chg_bit) bus.baud_div_i = 16'(new_div);
            drive(b[k], len);
        end
        drive(stop, len);
    endtask

    task automatic expect_count(input string tag, input int n);
        check({tag, " count"}, 64'(evq.size()), 64'(n));
    endtask

    task automatic expect_pop(input string tag, input logic err, input int c, input logic [7:0] d);
        evt_t ev;
        if (evq.size() == 0) return;
        ev = evq.pop_front();
        check({tag, " kind"}, 64'(ev.err), 64'(err));
        check({tag, " cycle"}, 64'(ev.cyc), 64'(c));
        check({tag, " data"}, 64'(ev.d), 64'(d));
    endtask

    initial begin
        int e, e2, d;
        logic [7:0] b;
        bus.rx_pin_in  = 1'b1;
        bus.baud_div_i = 16'd16;
        #1 rst = 1'b1;
        #2;
        check("reset data", 64'(bus.rx_data_o), 64'd0);
        check("reset valid", 64'(bus.valid_o), 64'd0);
        check("reset ferr", 64'(bus.frame_err_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 4);

        send(8'hA5, 16, 1'b1, -1, 0, e);
        drive(1'b1, 10);
        expect_count("a5", 1);
        expect_pop("a5", 1'b0, exp_cyc(e, 16), 8'hA5);
        check("a5 busy idle", 64'(bus.busy_o), 64'd0);

        send(8'hA5, 16, 1'b0, -1, 0, e);
        drive(1'b0, 40);
        check("break busy", 64'(bus.busy_o), 64'd1);
        expect_count("ferr", 1);
        expect_pop("ferr", 1'b1, exp_cyc(e, 16), 8'hA5);
        check("ferr data kept", 64'(bus.rx_data_o), 64'hA5);
        drive(1'b1, 5);
        check("break released", 64'(bus.busy_o), 64'd0);

        drive(1'b0, 5);
        check("glitch busy", 64'(bus.busy_o), 64'd1);
        drive(1'b1, 20);
        check("glitch idle", 64'(bus.busy_o), 64'd0);
        expect_count("glitch", 0);

        send(8'h00, 16, 1'b1, -1, 0, e);
        send(8'hFF, 16, 1'b1, -1, 0, e2);
        drive(1'b1, 10);
        expect_count("b2b", 2);
        expect_pop("b2b 00", 1'b0, exp_cyc(e, 16), 8'h00);
        expect_pop("b2b ff", 1'b0, exp_cyc(e2, 16), 8'hFF);

        send(8'h3C, 16, 1'b1, 3, 8, e);
        send(8'h81, 8, 1'b1, -1, 0, e2);
        drive(1'b1, 10);
        expect_count("divchg", 2);
        expect_pop("divchg 3c", 1'b0, exp_cyc(e, 16), 8'h3C);
        expect_pop("div8 81", 1'b0, exp_cyc(e2, 8), 8'h81);

        bus.baud_div_i = 16'd2;
        b = 8'($urandom);
        send(b, 4, 1'b1, -1, 0, e);
        drive(1'b1, 10);
        expect_count("clamp", 1);
        expect_pop("clamp", 1'b0, exp_cyc(e, 2), b);

        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(4, 24));
            bus.baud_div_i = 16'(d);
            b = 8'($urandom);
            send(b, d, 1'b1, -1, 0, e);
            drive(1'b1, int'($urandom_range(4, 12)));
            expect_count("rand", 1);
            expect_pop("rand", 1'b0, exp_cyc(e, d), b);
        end

        bus.baud_div_i = 16'd16;
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 8);
        #1 rst = 1'b1;
        #1;
        check("midrst data", 64'(bus.rx_data_o), 64'd0);
        check("midrst busy", 64'(bus.busy_o), 64'd0);
        check("midrst valid", 64'(bus.valid_o), 64'd0);
        check("midrst ferr", 64'(bus.frame_err_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 200);
        expect_count("midrst", 0);
        b = 8'($urandom);
        send(b, 16, 1'b1, -1, 0, e);
        drive(1'b1, 10);
        expect_count("post rst", 1);
        expect_pop("post rst", 1'b0, exp_cyc(e, 16), b);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
